// File: rtl/ocp_mem_slave_pkg.sv
// Shared OCP command/response types and helpers for the OCP SRAM slave.
package ocp_mem_slave_pkg;

    typedef enum logic [2:0] {
        CMD_IDLE = 3'd0,
        CMD_WR   = 3'd1,
        CMD_RD   = 3'd2,
        CMD_RDEX = 3'd3,
        CMD_RDL  = 3'd4,
        CMD_WRNP = 3'd5,
        CMD_WRC  = 3'd6,
        CMD_BCST = 3'd7
    } ocp_cmd_e;

    typedef enum logic [1:0] {
        RESP_NIL  = 2'd0,
        RESP_DVA  = 2'd1,
        RESP_FAIL = 2'd2,
        RESP_ERR  = 2'd3
    } ocp_resp_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Posted writes are the only command that completes without a response.
    function automatic logic cmd_has_resp(input ocp_cmd_e cmd);
        logic r;
        case (cmd)
            CMD_IDLE: r = 1'b0;
            CMD_WR:   r = 1'b0;
            default:  r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic cmd_is_read(input ocp_cmd_e cmd);
        logic r;
        case (cmd)
            CMD_RD:   r = 1'b1;
            CMD_RDEX: r = 1'b1;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ocp_mem_slave_fifo.sv
// Synchronous response FIFO holding {response code, data}; head is shown as NIL/0 when empty.
module ocp_resp_fifo
    import ocp_mem_slave_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              push,
    input  ocp_resp_e         push_resp,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output ocp_resp_e         head_resp,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic              full
);

    localparam int PW = clog2(DEPTH);

    ocp_resp_e         resp_mem_r [DEPTH];
    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic [PW:0]       wr_ptr_r;
    logic [PW:0]       rd_ptr_r;
    logic              do_push_s;
    logic              do_pop_s;

    // Pointer-compare status, guarded push/pop and head presentation.
    always_comb begin
        empty     = (wr_ptr_r == rd_ptr_r);
        full      = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        if (empty) begin
            head_resp = RESP_NIL;
            head_data = {DATA_W{1'b0}};
        end else begin
            head_resp = resp_mem_r[rd_ptr_r[PW-1:0]];
            head_data = data_mem_r[rd_ptr_r[PW-1:0]];
        end
    end

    // Pointer and storage update.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_r <= {(PW+1){1'b0}};
            rd_ptr_r <= {(PW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                resp_mem_r[i] <= RESP_NIL;
                data_mem_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (do_push_s) begin
                resp_mem_r[wr_ptr_r[PW-1:0]] <= push_resp;
                data_mem_r[wr_ptr_r[PW-1:0]] <= push_data;
                wr_ptr_r                     <= wr_ptr_r + 1'b1;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

endmodule

// File: rtl/ocp_mem_slave.sv
// OCP slave terminating requests on a 1-cycle-latency single-port SRAM, with
// credit-based accept so buffered responses can never overflow.
module ocp_mem_slave
    import ocp_mem_slave_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int RESP_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         resetb,
    input  ocp_cmd_e                     MCmd,
    input  logic [ADDR_W-1:0]            MAddr,
    input  logic [DATA_W-1:0]            MData,
    input  logic [DATA_W/8-1:0]          MByteEn,
    output logic                         SCmdAccept,
    output ocp_resp_e                    SResp,
    output logic [DATA_W-1:0]            SData,
    input  logic                         MRespAccept,
    output logic                         mem_en,
    output logic                         mem_we,
    output logic [clog2(MEM_WORDS)-1:0]  mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    output logic [DATA_W/8-1:0]          mem_be,
    input  logic [DATA_W-1:0]            mem_rdata
);

    localparam int BOFF = clog2(DATA_W/8);
    localparam int MA_W = clog2(MEM_WORDS);
    localparam int CR_W = clog2(RESP_DEPTH) + 1;
    localparam int HI_W = ADDR_W - BOFF - MA_W;

    logic [CR_W-1:0]   credit_r;
    logic              stg_vld_r;
    logic              stg_rd_r;
    ocp_resp_e         stg_resp_r;

    logic              acc_s;
    logic              in_range_s;
    logic              mem_op_s;
    logic              wr_op_s;
    logic              has_resp_s;
    logic              rd_ok_s;
    ocp_resp_e         resp_s;
    logic              dec_s;
    logic              pop_s;
    logic              push_s;
    logic [DATA_W-1:0] push_data_s;
    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic [BOFF-1:0]   addr_unused_s;

    assign addr_unused_s = MAddr[BOFF-1:0];

    // Request decode, SRAM strobes and credit bookkeeping inputs.
    always_comb begin
        SCmdAccept = (credit_r != {CR_W{1'b0}});
        acc_s      = (MCmd != CMD_IDLE) && SCmdAccept;
        in_range_s = (MAddr[ADDR_W-1:BOFF+MA_W] == {HI_W{1'b0}});
        has_resp_s = cmd_has_resp(MCmd);
        rd_ok_s    = cmd_is_read(MCmd) && in_range_s;
        mem_op_s   = 1'b0;
        wr_op_s    = 1'b0;
        resp_s     = RESP_NIL;
        case (MCmd)
            CMD_WR: begin
                mem_op_s = in_range_s;
                wr_op_s  = 1'b1;
            end
            CMD_WRNP: begin
                mem_op_s = in_range_s;
                wr_op_s  = 1'b1;
                resp_s   = in_range_s ? RESP_DVA : RESP_ERR;
            end
            CMD_RD, CMD_RDEX: begin
                mem_op_s = in_range_s;
                resp_s   = in_range_s ? RESP_DVA : RESP_ERR;
            end
            CMD_RDL, CMD_WRC, CMD_BCST: begin
                resp_s = RESP_ERR;
            end
            default: begin
                resp_s = RESP_NIL;
            end
        endcase
        // The resetb term keeps the SRAM quiet while reset is asserted.
        mem_en      = acc_s && mem_op_s && resetb;
        mem_we      = mem_en && wr_op_s;
        mem_addr    = MAddr[BOFF+MA_W-1:BOFF];
        mem_wdata   = MData;
        mem_be      = MByteEn;
        dec_s       = acc_s && has_resp_s;
        pop_s       = !fifo_empty_s && MRespAccept;
        push_s      = stg_vld_r && !fifo_full_s;
        push_data_s = stg_rd_r ? mem_rdata : {DATA_W{1'b0}};
    end

    // Credit counter: free response slots across stage register and FIFO.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            credit_r <= CR_W'(RESP_DEPTH);
        end else if (dec_s && !pop_s) begin
            credit_r <= credit_r - 1'b1;
        end else if (!dec_s && pop_s) begin
            credit_r <= credit_r + 1'b1;
        end else begin
            credit_r <= credit_r;
        end
    end

    // Stage register aligns the response with the SRAM read data one cycle later.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            stg_vld_r  <= 1'b0;
            stg_rd_r   <= 1'b0;
            stg_resp_r <= RESP_NIL;
        end else begin
            stg_vld_r  <= dec_s;
            stg_rd_r   <= acc_s && rd_ok_s;
            stg_resp_r <= resp_s;
        end
    end

    ocp_resp_fifo #(
        .DEPTH  (RESP_DEPTH),
        .DATA_W (DATA_W)
    ) u_resp_fifo (
        .clk       (clk),
        .resetb    (resetb),
        .push      (push_s),
        .push_resp (stg_resp_r),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head_resp (SResp),
        .head_data (SData),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s)
    );

endmodule
